// File: rtl/mov_avg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mov_avg_pkg
// Description : Shared helpers and default configuration for the
//               multi-channel moving-average scheduler.
//               - clog2      : constant-width helper (minimum 1 bit)
//               - CH_W       : channel-index width for the default build
//               - SUM_W      : running-sum width for the default build
//               - chan_state_t : per-channel state record (default build)
// Revision    : 1.0 - initial release
// ============================================================================
package mov_avg_pkg;

  // Ceiling log2, never less than 1 so that index fields are always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_WINDOW_SHIFT = 2;

  localparam int CH_W  = clog2(DEF_CHANNELS);
  // WINDOW samples of WIDTH bits sum to at most WIDTH+WINDOW_SHIFT bits.
  localparam int SUM_W = DEF_WIDTH + DEF_WINDOW_SHIFT;

  // Per-channel record layout at the default configuration. The top sizes
  // its own per-field arrays from its parameters so other builds still work.
  typedef struct packed {
    logic [SUM_W-1:0]            sum;
    logic [DEF_WINDOW_SHIFT-1:0] wp;
    logic [DEF_WINDOW_SHIFT:0]   fill;
  } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/mov_avg_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mov_avg_sched_if
// Description : Request/grant and result bundle of mov_avg_sched.
//   enable : arbitration enable          ivalid : per-channel request
//   idata  : packed per-channel samples  iready : one-hot grant
//   clear  : per-channel state flush     odata  : averaged result
//   ochan  : channel of odata            ovalid : single-cycle result strobe
//   modport slave  : the scheduler side
//   modport master : the source/sink side
// Revision    : 1.0 - initial release
// ============================================================================
interface mov_avg_sched_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  import mov_avg_pkg::*;

  localparam int OCH_W = clog2(CHANNELS);

  logic                      enable;
  logic [CHANNELS-1:0]       ivalid;
  logic [CHANNELS*WIDTH-1:0] idata;
  logic [CHANNELS-1:0]       iready;
  logic [CHANNELS-1:0]       clear;
  logic [WIDTH-1:0]          odata;
  logic [OCH_W-1:0]          ochan;
  logic                      ovalid;

  modport slave (
    input  enable, ivalid, idata, clear,
    output iready, odata, ochan, ovalid
  );

  modport master (
    output enable, ivalid, idata, clear,
    input  iready, odata, ochan, ovalid
  );

endinterface
`default_nettype wire

// File: rtl/mov_avg_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, one grant per cycle.
//   clock, reset : system clock, synchronous active-high reset
//   req[N]       : qualified requests
//   advance      : move the priority pointer to the current winner
//   gnt[N]       : one-hot grant (combinational)
//   gnt_idx      : index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mov_avg_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic [N-1:0]  req,
  input  wire logic          advance,
  output logic      [N-1:0]  gnt,
  output logic      [IW-1:0] gnt_idx
);

  // Last winner; the search starts just above it. Resets to N-1 so that
  // channel 0 has top priority after reset.
  logic [IW-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= gnt_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mov_avg_sched.sv
`default_nettype none
// ============================================================================
// Module      : mov_avg_sched
// Description : Time-multiplexed moving-average engine. A round-robin
//               arbiter picks one channel per cycle; its running sum and
//               sample history are updated and the window average is
//               emitted one cycle later, tagged with the channel number.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : mov_avg_sched_if.slave (enable, ivalid, idata, clear,
//                  iready, odata, ochan, ovalid)
// Build option : MOV_AVG_WARMUP_MASK_EN - suppress ovalid for a channel
//                until WINDOW samples have been taken since reset/clear.
// Revision    : 1.0 - initial release
// ============================================================================
module mov_avg_sched
  import mov_avg_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int WINDOW_SHIFT = DEF_WINDOW_SHIFT
) (
  input  wire logic     clock,
  input  wire logic     reset,
  mov_avg_sched_if.slave bus
);

  localparam int WINDOW = 1 << WINDOW_SHIFT;
  localparam int S_W    = WIDTH + WINDOW_SHIFT;
  localparam int C_W    = clog2(CHANNELS);

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] gnt;
  logic [C_W-1:0]      gnt_idx;
  logic                accept;
  logic                emit;

  // Cleared channels are withheld so their sample stays pending.
  assign req = (bus.enable && !reset) ? (bus.ivalid & ~bus.clear) : '0;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.iready = gnt;
  assign accept     = |gnt;

  // Per-channel state
  logic [WIDTH-1:0]        hist [CHANNELS][WINDOW];
  logic [S_W-1:0]          sum  [CHANNELS];
  logic [WINDOW_SHIFT-1:0] wp   [CHANNELS];

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] oldest;
  logic [S_W-1:0]   new_sum;

  assign x       = bus.idata[gnt_idx*WIDTH +: WIDTH];
  assign oldest  = hist[gnt_idx][wp[gnt_idx]];
  // Slot being overwritten is the sample leaving the window; zero during
  // warm-up, which gives the "missing history counts as zero" behaviour.
  assign new_sum = sum[gnt_idx] + S_W'(x) - S_W'(oldest);

`ifdef MOV_AVG_WARMUP_MASK_EN
  localparam logic [WINDOW_SHIFT:0] FILL_LAST = (WINDOW_SHIFT+1)'(WINDOW - 1);
  localparam logic [WINDOW_SHIFT:0] FILL_FULL = (WINDOW_SHIFT+1)'(WINDOW);
  logic [WINDOW_SHIFT:0] fill [CHANNELS];
  // This accept completes (or follows) a full window.
  assign emit = accept && (fill[gnt_idx] >= FILL_LAST);
`else
  assign emit = accept;
`endif

  logic [WIDTH-1:0] odata_q;
  logic [C_W-1:0]   ochan_q;
  logic             ovalid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      ochan_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        sum[k] <= '0;
        wp[k]  <= '0;
`ifdef MOV_AVG_WARMUP_MASK_EN
        fill[k] <= '0;
`endif
        for (int j = 0; j < WINDOW; j++) hist[k][j] <= '0;
      end
    end else begin
      // A cleared channel can never be the granted one this cycle.
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.clear[k]) begin
          sum[k] <= '0;
          wp[k]  <= '0;
`ifdef MOV_AVG_WARMUP_MASK_EN
          fill[k] <= '0;
`endif
          for (int j = 0; j < WINDOW; j++) hist[k][j] <= '0;
        end
      end
      if (accept) begin
        hist[gnt_idx][wp[gnt_idx]] <= x;
        wp[gnt_idx]                <= wp[gnt_idx] + 1'b1;
        sum[gnt_idx]               <= new_sum;
`ifdef MOV_AVG_WARMUP_MASK_EN
        if (fill[gnt_idx] != FILL_FULL) fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
`endif
      end
      ovalid_q <= emit;
      if (emit) begin
        odata_q <= WIDTH'(new_sum >> WINDOW_SHIFT);
        ochan_q <= gnt_idx;
      end
    end
  end

  assign bus.odata  = odata_q;
  assign bus.ochan  = ochan_q;
  assign bus.ovalid = ovalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mov_avg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mov_avg_sched
// Description : Directed, table-driven bench for mov_avg_sched (4 channels,
//               32-bit samples, window of 4). Expectations follow the
//               MOV_AVG_WARMUP_MASK_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mov_avg_sched;

`ifdef MOV_AVG_WARMUP_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mov_avg_sched_if #(.WIDTH(32), .CHANNELS(4)) bus ();

  mov_avg_sched #(.WIDTH(32), .CHANNELS(4), .WINDOW_SHIFT(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    bit           rst;
    bit           en;
    logic [3:0]   vld;
    logic [3:0]   clr;
    logic [127:0] data;
    logic [3:0]   rdy;   // expected grant
    bit           acc;   // a sample is accepted this cycle
    bit           warm;  // this accept completes a full window
    logic [31:0]  od;
    logic [1:0]   oc;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [127:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {32'(d3), 32'(d2), 32'(d1), 32'(d0)};
  endfunction

  function automatic vec_t mk(input bit r, input bit e, input logic [3:0] vl,
                              input logic [3:0] cl, input logic [127:0] d,
                              input logic [3:0] rd, input bit a, input bit w,
                              input int od, input int oc);
    vec_t v;
    v.rst = r; v.en = e; v.vld = vl; v.clr = cl; v.data = d;
    v.rdy = rd; v.acc = a; v.warm = w; v.od = 32'(od); v.oc = 2'(oc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bit ev;
    rst        = v.rst;
    bus.enable = v.en;
    bus.ivalid = v.vld;
    bus.clear  = v.clr;
    bus.idata  = v.data;
    #1;
    chk($sformatf("v%0d iready", i), 32'(bus.iready), 32'(v.rdy));
    @(posedge clk); #1;
    ev = v.acc && (!MASK || v.warm);
    chk($sformatf("v%0d ovalid", i), 32'(bus.ovalid), 32'(ev));
    if (ev || v.rst) begin
      chk($sformatf("v%0d odata", i), bus.odata, v.od);
      chk($sformatf("v%0d ochan", i), 32'(bus.ochan), 32'(v.oc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int od_ch0 [5] = '{0, 0, 1, 2, 3};
    int grant_order [4] = '{3, 0, 1, 2};
    int n;

    // ---------------- table construction ----------------
    // All four channels held busy with constants 4,8,12,16: order 0,1,2,3.
    for (int r = 1; r <= 4; r++)
      for (int c = 0; c < 4; c++)
        vq.push_back(mk(0, 1, 4'hF, 4'h0, pk(4, 8, 12, 16), 4'(1 << c),
                        1, r == 4, r * (c + 1), c));
    vq.push_back(mk(0, 1, 4'h0, 4'hF, '0, 4'h0, 0, 0, 0, 0));
    // Channel 0 alone, samples 1..5.
    for (int s = 1; s <= 5; s++)
      vq.push_back(mk(0, 1, 4'h1, 4'h0, pk(s, 0, 0, 0), 4'h1, 1, s >= 4, od_ch0[s-1], 0));
    // Channels 1 (16s) and 2 (8s) alternate.
    for (int i = 0; i < 8; i++) begin
      n = i / 2 + 1;
      if (i % 2 == 0)
        vq.push_back(mk(0, 1, 4'h6, 4'h0, pk(0, 16, 8, 0), 4'h2, 1, n == 4, 4 * n, 1));
      else
        vq.push_back(mk(0, 1, 4'h6, 4'h0, pk(0, 16, 8, 0), 4'h4, 1, n == 4, 2 * n, 2));
    end
    // clear[1] with ch1 requesting: ch1 withheld, ch2 served.
    vq.push_back(mk(0, 1, 4'h6, 4'h2, pk(0, 16, 8, 0), 4'h4, 1, 1, 8, 2));
    vq.push_back(mk(0, 1, 4'h6, 4'h0, pk(0, 16, 8, 0), 4'h2, 1, 0, 4, 1));
    vq.push_back(mk(0, 1, 4'h6, 4'h0, pk(0, 16, 8, 0), 4'h4, 1, 1, 8, 2));
    // Enable gap of 3 cycles; the first one also clears every channel.
    vq.push_back(mk(0, 0, 4'hF, 4'hF, pk(4, 8, 12, 16), 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 4'hF, 4'h0, pk(4, 8, 12, 16), 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 4'hF, 4'h0, pk(4, 8, 12, 16), 4'h0, 0, 0, 0, 0));
    // Resume after last winner (ch2); cleared state gives data/4.
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 1, 4'hF, 4'h0, pk(4, 8, 12, 16), 4'(1 << grant_order[i]),
                      1, 0, grant_order[i] + 1, grant_order[i]));
    // Reset in the middle of channel 0 traffic.
    vq.push_back(mk(0, 1, 4'h0, 4'hF, '0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 4'h1, 4'h0, pk(40, 0, 0, 0), 4'h1, 1, 0, 10, 0));
    vq.push_back(mk(0, 1, 4'h1, 4'h0, pk(40, 0, 0, 0), 4'h1, 1, 0, 20, 0));
    vq.push_back(mk(1, 1, 4'h1, 4'h0, pk(40, 0, 0, 0), 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 4'h1, 4'h0, pk(40, 0, 0, 0), 4'h1, 1, 0, 10, 0));

    // ---------------- initial reset ----------------
    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.ivalid = 4'hF;
    bus.clear  = 4'h0;
    bus.idata  = pk(1, 2, 3, 4);
    @(posedge clk); #1;
    chk("reset iready", 32'(bus.iready), 32'h0);
    @(posedge clk); #1;
    chk("reset ovalid", 32'(bus.ovalid), 32'h0);
    chk("reset odata",  bus.odata, 32'h0);
    chk("reset ochan",  32'(bus.ochan), 32'h0);
    rst = 1'b0;

    // ---------------- table ----------------
    foreach (vq[i]) run_vec(i, vq[i]);

    // ---------------- channel 3: bounded wait, then back-to-back ----------------
    bus.enable = 1'b1;
    bus.clear  = 4'h0;
    bus.ivalid = 4'h8;
    bus.idata  = pk(0, 0, 0, 20);
    #1;
    n = 0;
    while (!bus.iready[3] && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (!bus.iready[3]) begin
      fails++;
      $display("FAIL ch3 grant wait: no grant after %0d cycles, expected within 8", n);
    end else begin
      for (int k = 1; k <= 4; k++) begin
        chk($sformatf("b2b%0d iready", k), 32'(bus.iready), 32'h8);
        @(posedge clk); #1;
        chk($sformatf("b2b%0d ovalid", k), 32'(bus.ovalid), 32'(!MASK || k == 4));
        if (!MASK || k == 4) begin
          chk($sformatf("b2b%0d odata", k), bus.odata, 32'(5 * k));
          chk($sformatf("b2b%0d ochan", k), 32'(bus.ochan), 32'd3);
        end
      end
    end
    // Request withdrawn: no pulse, result registers hold.
    bus.ivalid = 4'h0;
    @(posedge clk); #1;
    chk("idle ovalid", 32'(bus.ovalid), 32'h0);
    chk("idle odata hold", bus.odata, 32'd20);
    chk("idle ochan hold", 32'(bus.ochan), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
